// File: rtl/duty_modulator.sv
// duty_modulator: scales every duty value by a global factor using one shared multiplier,
// and commits the full scaled array in a single cycle with an UPDATE strobe.
module duty_modulator #(
  parameter int WIDTH = 13,
  parameter int TRANS_NUM = 249
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [7:0]       M,
  input  logic [WIDTH-1:0] DUTY_IN  [0:TRANS_NUM-1],
  output logic [WIDTH-1:0] DUTY_OUT [0:TRANS_NUM-1],
  output logic             UPDATE,
  output logic             BUSY
);
  localparam int IW = TRANS_NUM > 1 ? $clog2(TRANS_NUM) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, COMMIT} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx, a_idx, b_idx;
  logic [7:0] m_reg;
  logic [WIDTH-1:0] a_duty;
  logic [WIDTH+7:0] b_p;
  logic a_valid, b_valid, pending, drain_cnt, launch, last;
  logic [WIDTH-1:0] shadow [0:TRANS_NUM-1];
  assign last = idx == IW'(TRANS_NUM - 1);
  // A request seen in COMMIT (pending or arriving on that very edge) restarts without passing IDLE
  assign launch = (state == IDLE && START) || (state == COMMIT && (pending || START));
  assign BUSY = state != IDLE;
  always_comb begin
    state_nx = launch ? RUN
             : state == RUN ? (last ? DRAIN : RUN)
             : state == DRAIN ? (drain_cnt ? COMMIT : DRAIN)
             : IDLE;
  end
  always_ff @(posedge CLK) state <= RST ? IDLE : state_nx;
  always_ff @(posedge CLK) begin
    if (RST) begin
      pending   <= 1'b0;
      drain_cnt <= 1'b0;
      a_valid   <= 1'b0;
      b_valid   <= 1'b0;
      UPDATE    <= 1'b0;
      idx       <= '0;
      a_idx     <= '0;
      b_idx     <= '0;
      m_reg     <= '0;
      a_duty    <= '0;
      b_p       <= '0;
      shadow    <= '{default: '0};
      DUTY_OUT  <= '{default: '0};
    end else begin
      pending   <= launch ? 1'b0 : (pending || (START && state != IDLE));
      drain_cnt <= state == DRAIN && !drain_cnt;
      UPDATE    <= state == COMMIT;
      if (launch) begin
        m_reg <= M;
        idx   <= '0;
      end else if (state == RUN) begin
        idx <= idx + IW'(1);
      end
      a_valid <= state == RUN;
      if (state == RUN) begin
        a_duty <= DUTY_IN[idx];
        a_idx  <= idx;
      end
      b_valid <= a_valid;
      b_idx   <= a_idx;
      b_p     <= {8'd0, a_duty} * {{WIDTH{1'b0}}, m_reg};
      if (b_valid) shadow[b_idx] <= WIDTH'(b_p >> 8);
      if (state == COMMIT) DUTY_OUT <= shadow;
    end
  end
endmodule

// File: tb/tb_duty_modulator.sv
// tb_duty_modulator: table vectors, randomized runs and timing sequences against a
// floor(d*m/256) reference model with a commit-time scoreboard.
module tb_duty_modulator;
  localparam int W = 13;
  localparam int N = 249;
  logic clk = 0, rst = 1, start = 0;
  logic [7:0] m = 0;
  logic [W-1:0] duty [0:N-1];
  logic [W-1:0] dout [0:N-1];
  logic update, busy;
  int n_cmp = 0, n_bad = 0;
  int exp_mem [0:3][0:N-1];
  int wr = 0, rd = 0;
  logic [W-1:0] prev [0:N-1];
  bit mon_en = 0;

  duty_modulator #(.WIDTH(W), .TRANS_NUM(N)) dut (
    .CLK(clk), .RST(rst), .START(start), .M(m),
    .DUTY_IN(duty), .DUTY_OUT(dout), .UPDATE(update), .BUSY(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_expected(input int mf);
    for (int i = 0; i < N; i++) exp_mem[wr % 4][i] = (int'(duty[i]) * mf) / 256;
    wr++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one isolated run from IDLE: START sampled at edge 0, commit expected at edge N+3
  task automatic run_once(input int mf);
    int lat;
    push_expected(mf);
    m = 8'(mf);
    start = 1;
    tick();
    start = 0;
    check("busy_at_start", busy, 1);
    lat = -1;
    for (int k = 1; k <= 400 && lat < 0; k++) begin
      tick();
      if (update) lat = k;
    end
    check("update_latency", lat, N + 3);
    if (lat >= 0) begin
      check("busy_at_commit", busy, 0);
      tick();
      check("update_width", update, 0);
    end
  endtask

  // scoreboard: DUTY_OUT may move only with UPDATE, and then must equal the model
  initial begin
    int diff, bad;
    forever begin
      tick();
      if (mon_en) begin
        diff = 0;
        for (int i = 0; i < N; i++) if (dout[i] != prev[i]) diff++;
        if (update) begin
          if (rd == wr) check("unexpected_update", 1, 0);
          else begin
            bad = 0;
            for (int i = 0; i < N; i++) if (int'(dout[i]) != exp_mem[rd % 4][i]) bad++;
            check("dout_commit_errors", bad, 0);
            rd++;
          end
        end else check("dout_stable_changes", diff, 0);
      end
      for (int i = 0; i < N; i++) prev[i] = dout[i];
    end
  end

  typedef struct {int ramp; int val; int mf; int idx; int exp;} vec_t;
  vec_t vt [6];

  initial begin
    int zeros, ups, up1, up2;
    vt[0] = '{0, 4096, 255, 0, 4080};
    vt[1] = '{1, 0, 128, 248, 3968};
    vt[2] = '{1, 0, 0, 100, 0};
    vt[3] = '{0, 8191, 255, 5, 8159};
    vt[4] = '{0, 1, 255, 0, 0};
    vt[5] = '{1, 0, 128, 1, 16};
    for (int i = 0; i < N; i++) duty[i] = '0;
    repeat (3) tick();
    rst = 0;
    mon_en = 1;
    check("reset_busy", busy, 0);
    check("reset_update", update, 0);
    for (int k = 0; k < 300; k++) begin
      tick();
      if (busy || update) check("idle_busy_update", {busy, update}, 0);
    end
    zeros = 0;
    for (int i = 0; i < N; i++) if (dout[i] == 0) zeros++;
    check("idle_dout_zero", zeros, N);

    // abort a run with reset at edge 100
    for (int i = 0; i < N; i++) duty[i] = W'($urandom_range(1, 8191));
    m = 8'd200;
    start = 1;
    tick();
    start = 0;
    for (int k = 1; k < 100; k++) tick();
    rst = 1;
    tick();
    rst = 0;
    check("abort_busy", busy, 0);
    check("abort_update", update, 0);
    repeat (300) tick();
    zeros = 0;
    for (int i = 0; i < N; i++) if (dout[i] == 0) zeros++;
    check("abort_dout_zero", zeros, N);
    run_once(200);

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < N; i++) duty[i] = vt[v].ramp != 0 ? W'(32 * i) : W'(vt[v].val);
      run_once(vt[v].mf);
      check($sformatf("vec%0d_dout", v), dout[vt[v].idx], vt[v].exp);
      repeat (2) tick();
    end

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) duty[i] = W'($urandom_range(0, 8191));
      run_once($urandom_range(0, 255));
      for (int k = 0; k < 50; k++) begin
        for (int i = 0; i < N; i++) duty[i] = W'($urandom_range(0, 8191));
        tick();
      end
    end

    // pending requests at edges 10 and 100 collapse into one restart at the commit edge
    for (int i = 0; i < N; i++) duty[i] = W'($urandom_range(0, 8191));
    push_expected(255);
    m = 8'd255;
    start = 1;
    tick();
    start = 0;
    m = 8'd64;
    push_expected(64);
    ups = 0; up1 = -1; up2 = -1;
    for (int k = 1; k <= 520; k++) begin
      tick();
      start = (k == 9 || k == 99);
      if (update) begin
        ups++;
        if (up1 < 0) up1 = k; else if (up2 < 0) up2 = k;
      end
      if ((k < 2 * (N + 3)) != busy) check($sformatf("pend_busy_edge%0d", k), busy, k < 2 * (N + 3));
    end
    check("pend_first_update", up1, N + 3);
    check("pend_second_update", up2, 2 * (N + 3));
    check("pend_update_count", ups, 2);
    check("pend_dout_quarter", dout[17], duty[17] >> 2);
    check("scoreboard_drained", rd, wr);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
